// File: rtl/decode_stage_hs.sv
// Register-read/decode stage: splits instr, reads a bypassed regfile, registers one output slot.
// Latency: 1 cycle from accept to the output registers; 1 instruction/cycle when unstalled.
// Backpressure: in_ready drops while the slot is held (out_ready=0) or a load-use hazard is pending.
module decode_stage_hs #(
    parameter int DATA_WIDTH     = 16,
    parameter int PC_WIDTH       = 16,
    parameter int OPCODE_WIDTH   = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int IMM_WIDTH      = 16,
    parameter int INSTR_WIDTH    = OPCODE_WIDTH + 2*REG_ADDR_WIDTH + IMM_WIDTH,
    parameter logic [OPCODE_WIDTH-1:0] LOAD_OPCODE_0 = 6'd0,
    parameter logic [OPCODE_WIDTH-1:0] LOAD_OPCODE_1 = 6'd1,
    parameter bit R0_ZERO        = 1'b1
) (
    input  logic                      clk_in,
    input  logic                      RST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_WIDTH-1:0]    instr,
    input  logic [PC_WIDTH-1:0]       pc_in,
    input  logic                      reg_en,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0]     reg_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_ADDR_WIDTH-1:0] A_addr,
    output logic [REG_ADDR_WIDTH-1:0] B_addr,
    output logic [DATA_WIDTH-1:0]     A,
    output logic [DATA_WIDTH-1:0]     B,
    output logic [DATA_WIDTH-1:0]     imm,
    output logic [OPCODE_WIDTH-1:0]   ctrl,
    output logic [PC_WIDTH-1:0]       pc_out,
    output logic [15:0]               stall_count
);

    localparam int DEPTH = 1 << REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]     rf [DEPTH];
    logic [OPCODE_WIDTH-1:0]   opcode_f;
    logic [REG_ADDR_WIDTH-1:0] reg1_f;
    logic [REG_ADDR_WIDTH-1:0] reg2_f;
    logic [IMM_WIDTH-1:0]      imm_f;
    logic [DATA_WIDTH-1:0]     imm_ext;
    logic [DATA_WIDTH-1:0]     rd_a;
    logic [DATA_WIDTH-1:0]     rd_b;
    logic                      slot_is_load;
    logic                      hazard;
    logic                      accept;
    logic                      wr_ok;

    assign opcode_f = instr[OPCODE_WIDTH-1:0];
    assign reg1_f   = instr[OPCODE_WIDTH +: REG_ADDR_WIDTH];
    assign reg2_f   = instr[OPCODE_WIDTH+REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign imm_f    = instr[INSTR_WIDTH-1 -: IMM_WIDTH];

    generate
        if (IMM_WIDTH < DATA_WIDTH) begin : g_sext
            assign imm_ext = {{(DATA_WIDTH-IMM_WIDTH){imm_f[IMM_WIDTH-1]}}, imm_f};
        end else begin : g_pass
            assign imm_ext = imm_f;
        end
    endgenerate

    assign wr_ok = reg_en && !(R0_ZERO && (reg_addr == '0));

    // Read ports see a same-cycle writeback; a hardwired r0 overrides even the bypass.
    always_comb begin
        rd_a = rf[reg1_f];
        if (reg_en && (reg_addr == reg1_f)) rd_a = reg_data;
        if (R0_ZERO && (reg1_f == '0))      rd_a = '0;
        rd_b = rf[reg2_f];
        if (reg_en && (reg_addr == reg2_f)) rd_b = reg_data;
        if (R0_ZERO && (reg2_f == '0))      rd_b = '0;
    end

    // The load's destination is its own reg1 field, captured as A_addr.
    assign slot_is_load = (ctrl == LOAD_OPCODE_0) || (ctrl == LOAD_OPCODE_1);
    assign hazard   = in_valid && out_valid && slot_is_load &&
                      ((reg1_f == A_addr) || (reg2_f == A_addr));
    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk_in) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else if (wr_ok) begin
            rf[reg_addr] <= reg_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            out_valid <= 1'b0;
            A_addr    <= '0;
            B_addr    <= '0;
            A         <= '0;
            B         <= '0;
            imm       <= '0;
            ctrl      <= '0;
            pc_out    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            A_addr    <= reg1_f;
            B_addr    <= reg2_f;
            A         <= rd_a;
            B         <= rd_b;
            imm       <= imm_ext;
            ctrl      <= opcode_f;
            pc_out    <= pc_in;
        end else if (out_ready && out_valid) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            stall_count <= '0;
        end else if (hazard && !flush && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_decode_stage_hs.sv
// Randomized + directed bench for decode_stage_hs against a slot/regfile reference model.
module tb_decode_stage_hs;

    logic        clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        RST, in_valid, reg_en, flush, out_ready;
    logic [31:0] instr;
    logic [15:0] pc_in, reg_data;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data_w;
    assign reg_data_w = {16'h0, reg_data};

    logic        in_ready, out_valid;
    logic [4:0]  A_addr, B_addr;
    logic [15:0] A, B, imm, pc_out, stall_count;
    logic [5:0]  ctrl;

    logic        in_ready_w, out_valid_w;
    logic [4:0]  A_addr_w, B_addr_w;
    logic [31:0] A_w, B_w, imm_w;
    logic [15:0] pc_out_w, stall_count_w;
    logic [5:0]  ctrl_w;

    decode_stage_hs dut (
        .clk_in(clk_in), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .reg_en(reg_en), .reg_addr(reg_addr),
        .reg_data(reg_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .A_addr(A_addr), .B_addr(B_addr), .A(A), .B(B), .imm(imm), .ctrl(ctrl),
        .pc_out(pc_out), .stall_count(stall_count)
    );

    decode_stage_hs #(.DATA_WIDTH(32), .IMM_WIDTH(16)) dut_w (
        .clk_in(clk_in), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_w),
        .instr(instr), .pc_in(pc_in), .reg_en(reg_en), .reg_addr(reg_addr),
        .reg_data(reg_data_w), .flush(flush), .out_valid(out_valid_w), .out_ready(out_ready),
        .A_addr(A_addr_w), .B_addr(B_addr_w), .A(A_w), .B(B_w), .imm(imm_w), .ctrl(ctrl_w),
        .pc_out(pc_out_w), .stall_count(stall_count_w)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: architectural register array plus one slot record.
    logic [15:0] regs [32];
    logic        m_vld;
    logic [15:0] m_a, m_b, m_imm, m_pc;
    logic [5:0]  m_ctrl;
    logic [4:0]  m_aa, m_ba;
    int          m_stall;

    function automatic logic [31:0] mk(input int op, input int r1, input int r2, input int im);
        logic [5:0]  o;
        logic [4:0]  a, b;
        logic [15:0] i;
        o = 6'(op); a = 5'(r1); b = 5'(r2); i = 16'(im);
        return {i, b, a, o};
    endfunction

    function automatic logic [15:0] mrd(input logic [4:0] a, input bit we,
                                        input logic [4:0] wa, input logic [15:0] wd);
        if (a == 5'd0) return 16'h0;
        if (we && wa == a) return wd;
        return regs[a];
    endfunction

    task automatic check_outs();
        chk("out_valid",   32'(out_valid),   32'(m_vld));
        chk("A",           32'(A),           32'(m_a));
        chk("B",           32'(B),           32'(m_b));
        chk("imm",         32'(imm),         32'(m_imm));
        chk("ctrl",        32'(ctrl),        32'(m_ctrl));
        chk("A_addr",      32'(A_addr),      32'(m_aa));
        chk("B_addr",      32'(B_addr),      32'(m_ba));
        chk("pc_out",      32'(pc_out),      32'(m_pc));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
        chk("w_out_valid", 32'(out_valid_w), 32'(m_vld));
        chk("w_A",         A_w,              {16'h0, m_a});
        chk("w_B",         B_w,              {16'h0, m_b});
        chk("w_imm",       imm_w,            {{16{m_imm[15]}}, m_imm});
        chk("w_ctrl",      32'(ctrl_w),      32'(m_ctrl));
        chk("w_pc_out",    32'(pc_out_w),    32'(m_pc));
        chk("w_stall",     32'(stall_count_w), 32'(m_stall));
        chk("w_addr",      32'({A_addr_w, B_addr_w}), 32'({m_aa, m_ba}));
    endtask

    // Called at a negedge: drive, check in_ready, advance model, wait one cycle, check slot.
    task automatic step(input bit rst, input bit v, input logic [31:0] ins, input int pc,
                        input bit we, input int wa, input int wd, input bit fl,
                        input bit ordy, input bit do_chk);
        logic [4:0]  r1, r2, wa5;
        logic [15:0] ra, rb, wd16;
        bit          hz, rdy, acc;
        wa5 = 5'(wa); wd16 = 16'(wd);
        RST = rst; in_valid = v; instr = ins; pc_in = 16'(pc);
        reg_en = we; reg_addr = wa5; reg_data = wd16; flush = fl; out_ready = ordy;
        #1;
        r1  = ins[10:6];
        r2  = ins[15:11];
        hz  = v && m_vld && (m_ctrl == 6'd0 || m_ctrl == 6'd1) && (r1 == m_aa || r2 == m_aa);
        rdy = !hz && (!m_vld || ordy);
        acc = v && rdy && !fl;
        if (do_chk) begin
            chk("in_ready",   32'(in_ready),   32'(rdy));
            chk("w_in_ready", 32'(in_ready_w), 32'(rdy));
        end
        ra = mrd(r1, we, wa5, wd16);
        rb = mrd(r2, we, wa5, wd16);
        if (rst) begin
            foreach (regs[i]) regs[i] = 16'h0;
            m_vld = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc = 0; m_ctrl = 0;
            m_aa = 0; m_ba = 0; m_stall = 0;
        end else begin
            if (we && wa5 != 5'd0) regs[wa5] = wd16;
            if (hz && !fl && m_stall < 65535) m_stall++;
            if (fl) m_vld = 0;
            else if (acc) begin
                m_vld = 1; m_a = ra; m_b = rb; m_imm = ins[31:16];
                m_ctrl = ins[5:0]; m_aa = r1; m_ba = r2; m_pc = 16'(pc);
            end else if (ordy) m_vld = 0;
        end
        @(negedge clk_in);
        if (do_chk) check_outs();
    endtask

    initial begin
        int s0;
        RST = 1; in_valid = 0; instr = 0; pc_in = 0; reg_en = 0; reg_addr = 0;
        reg_data = 0; flush = 0; out_ready = 0;
        @(negedge clk_in);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, mk(2, 1, 1, 1), 5, 1, 3, 7, 0, 1, 1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);

        // write r3=9, then ADD r3, r0, imm=-32768
        step(0, 0, 0, 0, 1, 3, 9, 0, 1, 1);
        step(0, 1, mk(2, 3, 0, 16'h8000), 1, 0, 0, 0, 0, 1, 1);
        chk("add_A", 32'(A), 32'd9);
        chk("add_B", 32'(B), 32'd0);
        chk("add_imm", 32'(imm), 32'h8000);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("w_imm_8000", imm_w, 32'hFFFF8000);

        // write bypass, and r0 hardwired to zero
        step(0, 1, mk(3, 2, 3, 0), 2, 1, 2, 16, 0, 1, 1);
        chk("bypass_A", 32'(A), 32'd16);
        step(0, 1, mk(2, 0, 0, 0), 3, 1, 0, 5, 0, 1, 1);
        chk("r0_bypass", 32'(A), 32'd0);
        step(0, 1, mk(2, 0, 0, 0), 4, 0, 0, 0, 0, 1, 1);
        chk("r0_read", 32'(A), 32'd0);

        // backpressure
        step(0, 1, mk(2, 1, 1, 16'h8001), 1024, 0, 0, 0, 0, 1, 1);
        chk("w_imm_8001", imm_w, 32'hFFFF8001);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, mk(2, 1, 1, 0), 2000, 0, 0, 0, 0, 0, 1);
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_pc", 32'(pc_out), 32'd1024);
        end
        step(0, 1, mk(2, 1, 1, 0), 2000, 0, 0, 0, 0, 1, 1);
        chk("bp_release_pc", 32'(pc_out), 32'd2000);

        // load-use: exactly one bubble
        step(0, 1, mk(0, 4, 1, 0), 10, 0, 0, 0, 0, 1, 1);
        chk("lw_ctrl", 32'(ctrl), 32'd0);
        s0 = m_stall;
        step(0, 1, mk(2, 1, 4, 0), 11, 0, 0, 0, 0, 1, 1);
        chk("lu_bubble", 32'(out_valid), 32'd0);
        step(0, 1, mk(2, 1, 4, 0), 11, 0, 0, 0, 0, 1, 1);
        chk("lu_add_valid", 32'(out_valid), 32'd1);
        chk("lu_add_pc", 32'(pc_out), 32'd11);
        chk("lu_stall", 32'(stall_count), 32'(s0 + 1));
        step(0, 1, mk(0, 4, 1, 0), 20, 0, 0, 0, 0, 1, 1);
        step(0, 1, mk(2, 5, 6, 0), 21, 0, 0, 0, 0, 1, 1);
        chk("nodep_pc", 32'(pc_out), 32'd21);

        // flush drops slot and incoming instr; the write still lands
        step(0, 1, mk(2, 1, 1, 0), 3333, 1, 7, 77, 1, 0, 1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_pc", 32'(pc_out), 32'd21);
        step(0, 1, mk(2, 7, 0, 0), 40, 0, 0, 0, 0, 1, 1);
        chk("flush_write", 32'(A), 32'd77);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            int op;
            op = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 1) : $urandom_range(0, 63);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)),
                 $urandom_range(0, 65535), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 65535), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0), 1);
        end

        // saturate the stall counter with a held load and a dependent waiter
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 1, mk(0, 4, 1, 0), 100, 0, 0, 0, 0, 1, 1);
        for (int n = 0; n < 65540; n++)
            step(0, 1, mk(2, 4, 0, 0), 101, 0, 0, 0, 0, 0, 0);
        step(0, 1, mk(2, 4, 0, 0), 101, 0, 0, 0, 0, 0, 1);
        chk("stall_sat", 32'(stall_count), 32'hFFFF);
        step(0, 1, mk(2, 4, 0, 0), 101, 0, 0, 0, 0, 1, 1);
        chk("stall_hold", 32'(stall_count), 32'hFFFF);
        chk("sat_bubble", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage_hs.md
# decode_stage_hs

Parametrised register-read/decode stage with a valid/ready handshake, placed between fetch (stage 1) and execute (stage 3). It splits the instruction into opcode, two register fields and an immediate. It reads a multi-port register file with write-through bypass and registers the operands, sign-extended immediate, control and PC into one output slot. Unlike the fixed-width decode stage, it adds backpressure, flush, load-use bubble insertion and a stall counter.

## Interface
Parameters:
- DATA_WIDTH, 16, register/operand width
- PC_WIDTH, 16, program counter width
- OPCODE_WIDTH, 6, opcode field width (instr LSBs)
- REG_ADDR_WIDTH, 5, register field width; register file depth is 2**REG_ADDR_WIDTH
- IMM_WIDTH, 16, immediate field width (instr MSBs); must be ≤ DATA_WIDTH
- INSTR_WIDTH, OPCODE_WIDTH+2*REG_ADDR_WIDTH+IMM_WIDTH, instruction width
- LOAD_OPCODE_0, 6'd0, first load opcode (LW)
- LOAD_OPCODE_1, 6'd1, second load opcode (LW_IMM)
- R0_ZERO, 1, if 1 register 0 reads as 0 and ignores writes

Ports:
- clk_in  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- in_valid  in  1  instr/pc_in valid
- in_ready  out  1  stage accepts this cycle
- instr  in  INSTR_WIDTH  opcode [OPCODE_WIDTH-1:0], reg1 next, reg2 next, imm MSBs
- pc_in  in  PC_WIDTH  PC of instr
- reg_en  in  1  writeback enable
- reg_addr  in  REG_ADDR_WIDTH  writeback address
- reg_data  in  DATA_WIDTH  writeback data
- flush  in  1  discard the output slot and the incoming instruction
- out_valid  out  1  output slot holds an instruction
- out_ready  in  1  execute consumes the slot
- A_addr, B_addr  out  REG_ADDR_WIDTH  registered reg1/reg2 fields
- A, B  out  DATA_WIDTH  registered operands (signed)
- imm  out  DATA_WIDTH  registered, sign-extended immediate
- ctrl  out  OPCODE_WIDTH  registered opcode
- pc_out  out  PC_WIDTH  registered PC
- stall_count  out  16  count of hazard-bubble cycles, saturating

## Operation
- Register file: 2**REG_ADDR_WIDTH × DATA_WIDTH, one write port, two combinational read ports.
  - Write occurs on the clock edge when reg_en=1, independent of handshake, flush or hazard. R0_ZERO=1 suppresses the write to address 0.
- Bypass: if reg_en=1 and reg_addr equals a read address in the same cycle, that read returns reg_data. The exception is address 0 with R0_ZERO=1, which returns 0.
- Accept condition: accept = in_valid & in_ready & ~flush. On accept, the slot captures:
  - A = read(reg1), B = read(reg2)
  - imm = sign-extended instr imm field
  - ctrl = opcode, A_addr = reg1, B_addr = reg2, pc_out = pc_in
  - out_valid is set to 1
- Captured operands are frozen while the slot is held. Later writes do not update A/B.
- Load-use hazard: hazard = in_valid & out_valid & (ctrl==LOAD_OPCODE_0 | ctrl==LOAD_OPCODE_1) & (reg1==A_addr | reg2==A_addr). The load destination is its reg1 field.
- in_ready = ~hazard & (~out_valid | out_ready).
- Slot update priority:
  1. RST
  2. flush → out_valid=0
  3. accept → load
  4. out_ready & out_valid → out_valid=0, which produces the bubble when hazard is set
  5. hold
- Data registers of an invalid slot keep their last values; consumers use only out_valid.
- stall_count increments by 1 each cycle with hazard=1 and ~flush, and saturates at 16'hFFFF.

## Timing
- Latency: 1 cycle from accept edge to the output registers.
- Throughput: 1 instruction per cycle with no hazard and out_ready=1.
- Load-use: exactly one bubble cycle (out_valid=0) between the load leaving and the dependent instruction appearing, provided out_ready=1. If out_ready=0, the load is held and in_ready stays 0.
- Reset values: out_valid=0; A, B, imm, ctrl, pc_out, A_addr, B_addr = 0; stall_count=0; all registers = 0.
- Reset mid-operation: the slot is dropped on the reset edge. A concurrent reg_en write is ignored during RST.
- Simultaneous flush and in_valid: the incoming instruction is dropped (not accepted). The writeback write still occurs.
- imm sign extension: bit IMM_WIDTH-1 is replicated; if IMM_WIDTH==DATA_WIDTH, imm is passed through unchanged.

## Test plan
- Reset then write r3=9 (reg_en). Next cycle ADD reg1=3 reg2=0 imm=-32768 → A=9, B=0, imm=-32768, out_valid=1 one cycle later.
- Bypass: same cycle as reg_en=1, reg_addr=2, reg_data=16, issue MUL reg1=2 reg2=3 → A=16. R0_ZERO=1: write 5 to r0, read r0 → 0.
- Backpressure: out_ready=0 with in_valid=1 for 3 cycles → in_ready=0, slot (pc_out=1024) stable. out_ready=1 → next instruction accepted and pc_out updates on the following edge.
- Load-use: LW reg1=4, then ADD reg2=4 back to back with out_ready=1 → one out_valid=0 cycle, ADD appears 2 cycles after LW, stall_count=1. ADD reg1=5 with no dependency → no bubble.
- Flush: flush=1 with slot valid and in_valid=1 → out_valid=0 next cycle, instruction not captured. A reg_en write in the same cycle is visible afterwards.
- Saturation/width: force 65536 hazard cycles → stall_count=16'hFFFF and holds. Build with DATA_WIDTH=32, IMM_WIDTH=16, imm=16'h8001 → imm=32'hFFFF8001.
